lbp_stream_p: RTL

Parametrised streaming successor to the fixed 128x128 LBP engine. It fetches the grey image once, in raster order, over the existing gray_req/gray_ready/gray_data read interface. Two internal line buffers plus a 3x3 window supply each neighbourhood, so no pixel is fetched twice. It writes one 8-bit LBP code per interior pixel to the LBP memory over lbp_valid/lbp_addr/lbp_data, with a configurable comparison threshold and comparison mode.

---
 rtl/lbp_pkg.sv | 24 ++
 rtl/lbp_line_buf.sv | 42 ++++
 rtl/lbp_stream_p.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/lbp_pkg.sv
// Shared types and constants for the streaming LBP engine.
package lbp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Bit positions of each neighbour in the LBP code, clockwise-free raster order.
    localparam int NB_TL = 0;
    localparam int NB_T  = 1;
    localparam int NB_TR = 2;
    localparam int NB_L  = 3;
    localparam int NB_R  = 4;
    localparam int NB_BL = 5;
    localparam int NB_B  = 6;
    localparam int NB_BR = 7;

    localparam logic MODE_GE = 1'b0;
    localparam logic MODE_GT = 1'b1;

endpackage

// File: rtl/lbp_line_buf.sv
// One-row delay line: every enabled shift returns the pixel written DEPTH shifts earlier.
module lbp_line_buf #(
    parameter int DEPTH = 128,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] mem_q [DEPTH];

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Read-before-write at the same slot: contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

    assign dout_o = mem_q[ptr_q];

endmodule

// File: rtl/lbp_stream_p.sv
// Streaming 3x3 LBP engine: single raster fetch, two line buffers, one code per interior pixel.
module lbp_stream_p
    import lbp_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int DW    = 8,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic [DW-1:0] gray_data,
    input  logic          cfg_mode,
    input  logic [DW-1:0] cfg_thr,
    output logic          lbp_valid,
    output logic [AW-1:0] lbp_addr,
    output logic [7:0]    lbp_data,
    output logic          finish,
    output state_e        dbg_state_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [AW-1:0] LAST_A = AW'(IMG_W * IMG_H - 1);
    localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
    localparam logic [AW-1:0] CTR_OFFS = AW'(IMG_W + 1);

    state_e state_q, state_d;

    logic          mode_q;
    logic [DW-1:0] thr_q;

    logic [AW-1:0] addr_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    logic          cap_v_q, cap_int_q;
    logic [AW-1:0] cap_a_q;
    logic          win_v_q, win_int_q;
    logic [AW-1:0] win_a_q;
    logic [DW-1:0] win_q [3][3];

    logic          lbp_valid_q;
    logic [AW-1:0] lbp_addr_q;
    logic [7:0]    lbp_data_q;

    logic [DW-1:0] lb1_out, lb2_out;
    logic [DW:0]   sum;
    logic [DW-1:0] nb [8];
    logic [7:0]    code;

    // Request is combinational on gray_ready so a stalled cycle never raises gray_req.
    always_comb begin
        state_d  = state_q;
        gray_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (gray_ready) state_d = FETCH;
            end
            FETCH: begin
                gray_req = gray_ready;
                if (gray_ready && addr_q == LAST_A) state_d = DRAIN;
            end
            DRAIN: begin
                if (!cap_v_q && !win_v_q) state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_GE;
            thr_q   <= '0;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && gray_ready) begin
                mode_q <= cfg_mode;
                thr_q  <= cfg_thr;
            end
            if (gray_req) begin
                if (addr_q != LAST_A) addr_q <= addr_q + 1'b1;
                if (col_q == LAST_C) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    // Pipeline tags: request edge -> capture edge -> code register edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_v_q     <= 1'b0;
            cap_int_q   <= 1'b0;
            cap_a_q     <= '0;
            win_v_q     <= 1'b0;
            win_int_q   <= 1'b0;
            win_a_q     <= '0;
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
        end else begin
            cap_v_q     <= gray_req;
            cap_int_q   <= gray_req && (row_q >= RW'(2)) && (col_q >= CW'(2));
            cap_a_q     <= addr_q;
            win_v_q     <= cap_v_q;
            win_int_q   <= cap_int_q;
            win_a_q     <= cap_a_q - CTR_OFFS;
            lbp_valid_q <= win_int_q;
            if (win_int_q) begin
                lbp_addr_q <= win_a_q;
                lbp_data_q <= code;
            end
        end
    end

    lbp_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
        .clk    (clk),
        .rst_n  (reset),
        .en_i   (cap_v_q),
        .din_i  (gray_data),
        .dout_o (lb1_out)
    );

    lbp_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb2 (
        .clk    (clk),
        .rst_n  (reset),
        .en_i   (cap_v_q),
        .din_i  (lb1_out),
        .dout_o (lb2_out)
    );

    // Row 0 of the window is the oldest line; column 2 holds the newest pixel.
    always_ff @(posedge clk) begin
        if (cap_v_q) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb2_out;
            win_q[1][2] <= lb1_out;
            win_q[2][2] <= gray_data;
        end
    end

    always_comb begin
        sum       = {1'b0, win_q[1][1]} + {1'b0, thr_q};
        nb[NB_TL] = win_q[0][0];
        nb[NB_T]  = win_q[0][1];
        nb[NB_TR] = win_q[0][2];
        nb[NB_L]  = win_q[1][0];
        nb[NB_R]  = win_q[1][2];
        nb[NB_BL] = win_q[2][0];
        nb[NB_B]  = win_q[2][1];
        nb[NB_BR] = win_q[2][2];
        code      = '0;
        for (int i = 0; i < 8; i++) begin
            if (sum[DW]) begin
                code[i] = 1'b0;
            end else if (mode_q == MODE_GT) begin
                code[i] = (nb[i] > sum[DW-1:0]);
            end else begin
                code[i] = (nb[i] >= sum[DW-1:0]);
            end
        end
    end

    assign gray_addr   = addr_q;
    assign lbp_valid   = lbp_valid_q;
    assign lbp_addr    = lbp_addr_q;
    assign lbp_data    = lbp_data_q;
    assign finish      = (state_q == DONE);
    assign dbg_state_o = state_q;

endmodule
